// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, types and helpers.
package vga_pkg;

  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_DISPLAY = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned CLK_DIV   = 2;

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Colour bit positions inside an rgb_t
  localparam int unsigned BLUE  = 2;
  localparam int unsigned GREEN = 1;
  localparam int unsigned RED   = 0;

  localparam int unsigned CNT_W = 10;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [2:0]       rgb_t;

  // Inclusive range test used for the sync pulse decode
  function automatic logic in_range(cnt_t v, cnt_t lo, cnt_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Bundle between the timing generator (master) and the pixel-colour block (slave).
interface vga_sync_gen_if;
  import vga_pkg::*;

  rgb_t rgb_in;
  cnt_t hcount;
  cnt_t vcount;
  logic p_tick;
  logic frame_start;
  logic hsync;
  logic vsync;
  logic video_on;
  rgb_t rgb_out;

  modport master (
    input  rgb_in,
    output hcount, vcount, p_tick, frame_start, hsync, vsync, video_on, rgb_out
  );

  modport slave (
    output rgb_in,
    input  hcount, vcount, p_tick, frame_start, hsync, vsync, video_on, rgb_out
  );

endinterface

// File: rtl/vga_pix_tick.sv
// Clock divider: one-clk pixel tick every CLK_DIV board clocks.
module vga_pix_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_p_tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_div_cnt_d;

  // Wrap at CLK_DIV-1; with CLK_DIV=1 the counter stays at 0 and the tick is constant
  always_comb begin
    w_div_cnt_d = r_div_cnt + DIV_W'(1);
    if (r_div_cnt == DIV_LAST) begin
      w_div_cnt_d = '0;
    end
  end

  // Divider state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= w_div_cnt_d;
    end
  end

  assign o_p_tick = (r_div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel counters, sync decode and registered colour/sync output stage.
module vga_sync_gen import vga_pkg::*; #(
  parameter int unsigned H_DISPLAY = vga_pkg::H_DISPLAY,
  parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
  parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK    = vga_pkg::H_BACK,
  parameter int unsigned V_DISPLAY = vga_pkg::V_DISPLAY,
  parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
  parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_pkg::V_BACK,
  parameter int unsigned CLK_DIV   = vga_pkg::CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vga_sync_gen_if.master        bus
);

  localparam int unsigned HTOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam cnt_t H_LAST   = cnt_t'(HTOT - 1);
  localparam cnt_t V_LAST   = cnt_t'(VTOT - 1);
  localparam cnt_t H_VIS    = cnt_t'(H_DISPLAY);
  localparam cnt_t V_VIS    = cnt_t'(V_DISPLAY);
  localparam cnt_t HS_FIRST = cnt_t'(H_DISPLAY + H_FRONT);
  localparam cnt_t HS_LAST  = cnt_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam cnt_t VS_FIRST = cnt_t'(V_DISPLAY + V_FRONT);
  localparam cnt_t VS_LAST  = cnt_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic w_p_tick;

  vga_pix_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .o_p_tick (w_p_tick)
  );

  cnt_t r_hcount, r_vcount;
  cnt_t w_hcount_d, w_vcount_d;

  // Raster advance: one pixel per tick, line and frame wrap on the same edge
  always_comb begin
    w_hcount_d = r_hcount;
    w_vcount_d = r_vcount;
    if (w_p_tick) begin
      if (r_hcount == H_LAST) begin
        w_hcount_d = '0;
        w_vcount_d = (r_vcount == V_LAST) ? '0 : r_vcount + cnt_t'(1);
      end else begin
        w_hcount_d = r_hcount + cnt_t'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else begin
      r_hcount <= w_hcount_d;
      r_vcount <= w_vcount_d;
    end
  end

  logic w_h_active, w_v_active, w_visible, w_hs0, w_vs0;

  // Stage 0 decode from the current counters
  always_comb begin
    w_h_active = (r_hcount < H_VIS);
    w_v_active = (r_vcount < V_VIS);
    w_visible  = w_h_active & w_v_active;
    w_hs0      = ~in_range(r_hcount, HS_FIRST, HS_LAST);
    w_vs0      = ~in_range(r_vcount, VS_FIRST, VS_LAST);
  end

  logic r_hsync, r_vsync, r_video_on;
  rgb_t r_rgb_out;

  // Stage 1: syncs and blanked colour share one pixel of latency so they stay aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_video_on <= 1'b0;
      r_rgb_out  <= '0;
    end else if (w_p_tick) begin
      r_hsync    <= w_hs0;
      r_vsync    <= w_vs0;
      r_video_on <= w_visible;
      r_rgb_out  <= w_visible ? bus.rgb_in : '0;
    end
  end

  // Counters go straight out of their registers so the pixel block sees clean inputs
  assign bus.hcount      = r_hcount;
  assign bus.vcount      = r_vcount;
  assign bus.p_tick      = w_p_tick;
  assign bus.frame_start = w_p_tick & (r_hcount == '0) & (r_vcount == '0);
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.video_on    = r_video_on;
  assign bus.rgb_out     = r_rgb_out;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size timing for horizontal behaviour, a scaled raster for whole frames.
module tb_vga_sync_gen;

  // Scaled raster: 25 pixels x 15 lines, hsync low 18..21, vsync low lines 10..11
  localparam int S_HT = 25;
  localparam int S_VT = 15;

  logic clk;
  logic rst_n;
  logic force_white;

  int n_vec;
  int n_bad;

  vga_sync_gen_if if_full ();
  vga_sync_gen_if if_small ();
  vga_sync_gen_if if_div1 ();

  assign if_full.rgb_in  = force_white ? 3'b111 : if_full.hcount[2:0];
  assign if_small.rgb_in = force_white ? 3'b111 : if_small.hcount[2:0];
  assign if_div1.rgb_in  = force_white ? 3'b111 : if_div1.hcount[2:0];

  vga_sync_gen #(
    .CLK_DIV (2)
  ) u_full (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_full)
  );

  vga_sync_gen #(
    .H_DISPLAY (16), .H_FRONT (2), .H_SYNC (4), .H_BACK (3),
    .V_DISPLAY (8),  .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
    .CLK_DIV   (2)
  ) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_small)
  );

  vga_sync_gen #(
    .CLK_DIV (1)
  ) u_div1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_div1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic wait_tick_full(input int h, input int v, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (if_full.p_tick === 1'b1 && int'(if_full.hcount) == h && int'(if_full.vcount) == v)
        ok = 1'b1;
    end
  endtask

  task automatic wait_tick_small(input int h, input int v, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (if_small.p_tick === 1'b1 && int'(if_small.hcount) == h && int'(if_small.vcount) == v)
        ok = 1'b1;
    end
  endtask

  task automatic next_tick_full(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 8 && !ok; n++) begin
      @(negedge clk);
      if (if_full.p_tick === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic next_tick_small(output bit ok, output int clks);
    ok   = 1'b0;
    clks = 0;
    for (int n = 0; n < 8 && !ok; n++) begin
      @(negedge clk);
      clks++;
      if (if_small.p_tick === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    force_white = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({if_full.hcount, if_full.vcount} !== 20'd0) begin
      n_bad++;
      $display("FAIL reset_counters got h=%0d v=%0d want 0 0", if_full.hcount, if_full.vcount);
    end
    n_vec++;
    if ({if_full.hsync, if_full.vsync, if_full.video_on, if_full.rgb_out} !== 6'b110000) begin
      n_bad++;
      $display("FAIL reset_outputs got hs=%b vs=%b von=%b rgb=%b want 1 1 0 000",
               if_full.hsync, if_full.vsync, if_full.video_on, if_full.rgb_out);
    end
    n_vec++;
    if ({if_full.p_tick, if_full.frame_start} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_tick got p_tick=%b fs=%b want 0 0", if_full.p_tick, if_full.frame_start);
    end
    n_vec++;
    if (if_div1.p_tick !== 1'b1) begin
      n_bad++;
      $display("FAIL div1_tick_in_reset got %b want 1", if_div1.p_tick);
    end

    rst_n       = 1'b1;
    force_white = 1'b0;
    @(negedge clk);  // after clk 1
    n_vec++;
    if ({if_full.p_tick, if_full.frame_start, if_full.hcount} !== {2'b11, 10'd0}) begin
      n_bad++;
      $display("FAIL first_tick got p_tick=%b fs=%b h=%0d want 1 1 0",
               if_full.p_tick, if_full.frame_start, if_full.hcount);
    end
    n_vec++;
    if (if_div1.hcount !== 10'd1) begin
      n_bad++;
      $display("FAIL div1_advance got h=%0d want 1", if_div1.hcount);
    end
    @(negedge clk);  // after clk 2
    n_vec++;
    if ({if_full.p_tick, if_full.hcount, if_full.video_on} !== {1'b0, 10'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL after_first_tick got p_tick=%b h=%0d von=%b want 0 1 1",
               if_full.p_tick, if_full.hcount, if_full.video_on);
    end
    n_vec++;
    if ({if_div1.p_tick, if_div1.hcount} !== {1'b1, 10'd2}) begin
      n_bad++;
      $display("FAIL div1_every_clk got p_tick=%b h=%0d want 1 2", if_div1.p_tick, if_div1.hcount);
    end
    @(negedge clk);  // after clk 3: no tick, everything holds
    n_vec++;
    if ({if_full.hcount, if_full.rgb_out} !== {10'd1, 3'b000}) begin
      n_bad++;
      $display("FAIL hold_between_ticks got h=%0d rgb=%b want 1 000", if_full.hcount, if_full.rgb_out);
    end
    @(negedge clk);  // after clk 4
    n_vec++;
    if ({if_full.hcount, if_full.rgb_out} !== {10'd2, 3'b001}) begin
      n_bad++;
      $display("FAIL second_pixel got h=%0d rgb=%b want 2 001", if_full.hcount, if_full.rgb_out);
    end
  endtask

  // Line 1 of the full raster: hsync low for 96 pixel periods, edges one pixel late
  task automatic test_hsync();
    bit ok;
    int lows;
    lows = 0;
    wait_tick_full(0, 1, 4000, ok);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL hsync_reach_line1 got timeout want (0,1)");
    end
    for (int i = 0; i < 800; i++) begin
      if (i > 0) next_tick_full(ok);
      if (if_full.hsync === 1'b0) lows++;
      if (i == 656 || i == 657 || i == 752 || i == 753) begin
        n_vec++;
        if (if_full.hsync !== ((i == 656 || i == 753) ? 1'b1 : 1'b0)) begin
          n_bad++;
          $display("FAIL hsync_edge h=%0d got %b want %b", i, if_full.hsync,
                   (i == 656 || i == 753) ? 1'b1 : 1'b0);
        end
      end
    end
    n_vec++;
    if ({if_full.hcount, if_full.vcount} !== {10'd799, 10'd1}) begin
      n_bad++;
      $display("FAIL hsync_line_end got h=%0d v=%0d want 799 1", if_full.hcount, if_full.vcount);
    end
    n_vec++;
    if (lows != 96) begin
      n_bad++;
      $display("FAIL hsync_width got %0d want 96", lows);
    end
  endtask

  // Line 2: rgb_out is the previous pixel's hcount[2:0] while visible, else 000
  task automatic test_blanking();
    bit ok;
    for (int i = 0; i < 800; i++) begin
      int   prev;
      logic exp_von;
      logic [2:0] exp_rgb;
      next_tick_full(ok);
      prev    = (i == 0) ? 799 : i - 1;
      exp_von = (prev < 640);
      exp_rgb = exp_von ? 3'(prev) : 3'b000;
      n_vec++;
      if ({if_full.video_on, if_full.rgb_out} !== {exp_von, exp_rgb}) begin
        n_bad++;
        $display("FAIL blank_align h=%0d got von=%b rgb=%b want %b %b", i,
                 if_full.video_on, if_full.rgb_out, exp_von, exp_rgb);
      end
    end
  endtask

  task automatic test_line_wrap();
    bit ok;
    wait_tick_full(799, 10, 20000, ok);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL wrap_reach got timeout want (799,10)");
    end
    @(negedge clk);
    n_vec++;
    if ({if_full.hcount, if_full.vcount} !== {10'd0, 10'd11}) begin
      n_bad++;
      $display("FAIL line_wrap got h=%0d v=%0d want 0 11", if_full.hcount, if_full.vcount);
    end
  endtask

  // One whole scaled frame from frame_start to the next frame_start
  task automatic test_vsync_frame();
    bit ok;
    int clks, step, vs_lows, first_low;
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      if (if_small.frame_start === 1'b1) ok = 1'b1;
    end
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL frame_start_seen got timeout want pulse");
    end
    clks      = 0;
    vs_lows   = 0;
    first_low = -1;
    for (int i = 0; i < S_HT * S_VT; i++) begin
      int p, ph, pv;
      logic exp_hs, exp_vs, exp_von;
      logic [2:0] exp_rgb;
      if (i > 0) begin
        next_tick_small(ok, step);
        clks += step;
      end
      p       = (i == 0) ? S_HT * S_VT - 1 : i - 1;
      ph      = p % S_HT;
      pv      = p / S_HT;
      exp_hs  = !(ph >= 18 && ph <= 21);
      exp_vs  = !(pv >= 10 && pv <= 11);
      exp_von = (ph < 16) && (pv < 8);
      exp_rgb = exp_von ? 3'(ph) : 3'b000;
      if (if_small.vsync === 1'b0) begin
        vs_lows++;
        if (first_low < 0) first_low = i;
      end
      n_vec++;
      if ({if_small.hcount, if_small.vcount, if_small.frame_start} !==
          {10'(i % S_HT), 10'(i / S_HT), (i == 0)}) begin
        n_bad++;
        $display("FAIL small_counters i=%0d got h=%0d v=%0d fs=%b want %0d %0d %b", i,
                 if_small.hcount, if_small.vcount, if_small.frame_start,
                 i % S_HT, i / S_HT, (i == 0));
      end
      n_vec++;
      if ({if_small.hsync, if_small.vsync} !== {exp_hs, exp_vs}) begin
        n_bad++;
        $display("FAIL small_sync i=%0d got hs=%b vs=%b want %b %b", i,
                 if_small.hsync, if_small.vsync, exp_hs, exp_vs);
      end
      n_vec++;
      if ({if_small.video_on, if_small.rgb_out} !== {exp_von, exp_rgb}) begin
        n_bad++;
        $display("FAIL small_video i=%0d got von=%b rgb=%b want %b %b", i,
                 if_small.video_on, if_small.rgb_out, exp_von, exp_rgb);
      end
    end
    n_vec++;
    if (vs_lows != 2 * S_HT || first_low != 10 * S_HT + 1) begin
      n_bad++;
      $display("FAIL vsync_window got lows=%0d first=%0d want %0d %0d",
               vs_lows, first_low, 2 * S_HT, 10 * S_HT + 1);
    end
    next_tick_small(ok, step);
    clks += step;
    n_vec++;
    if ({if_small.frame_start, if_small.hcount, if_small.vcount} !== {1'b1, 20'd0}) begin
      n_bad++;
      $display("FAIL frame_wrap got fs=%b h=%0d v=%0d want 1 0 0",
               if_small.frame_start, if_small.hcount, if_small.vcount);
    end
    n_vec++;
    if (clks != 2 * S_HT * S_VT) begin
      n_bad++;
      $display("FAIL frame_period got %0d clks want %0d", clks, 2 * S_HT * S_VT);
    end
    @(negedge clk);
    n_vec++;
    if (if_small.frame_start !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_start_width got %b want 0", if_small.frame_start);
    end
  endtask

  task automatic test_mid_frame_reset();
    bit ok;
    wait_tick_small(10, 5, 2000, ok);
    n_vec++;
    if (!ok || {if_small.video_on, if_small.rgb_out} !== 4'b1001) begin
      n_bad++;
      $display("FAIL pre_reset_state got ok=%b von=%b rgb=%b want 1 1 001",
               ok, if_small.video_on, if_small.rgb_out);
    end
    @(posedge clk);
    #5 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({if_small.hcount, if_small.vcount} !== 20'd0 || if_full.hcount !== 10'd0) begin
      n_bad++;
      $display("FAIL async_reset_counters got h=%0d v=%0d full_h=%0d want 0 0 0",
               if_small.hcount, if_small.vcount, if_full.hcount);
    end
    n_vec++;
    if ({if_small.hsync, if_small.vsync, if_small.video_on, if_small.rgb_out,
         if_small.p_tick} !== 7'b1100000) begin
      n_bad++;
      $display("FAIL async_reset_outputs got hs=%b vs=%b von=%b rgb=%b tick=%b want 1 1 0 000 0",
               if_small.hsync, if_small.vsync, if_small.video_on, if_small.rgb_out,
               if_small.p_tick);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_hsync();
    test_blanking();
    test_line_wrap();
    test_vsync_frame();
    test_mid_frame_reset();
    test_vsync_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing generator for the 640x480@60 Hz VGA output on the Spartan-3E board.
- Divides the 50 MHz board clock into a pixel tick.
- Runs the horizontal and vertical counters that feed the pixel-colour block (hcount, vcount).
- Registers the colour returned by that block, blanks it outside the visible area, and emits aligned hsync/vsync to the connector.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel; legal values are 1 and 2 or more

Ports:
- clk  in  1  board clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- rgb_in  in  3  colour from the pixel block, a combinational function of hcount/vcount; bit2 blue, bit1 green, bit0 red
- hcount  out  10  current pixel column, 0..H_TOTAL-1
- vcount  out  10  current line, 0..V_TOTAL-1
- p_tick  out  1  one-clk pulse per pixel period
- frame_start  out  1  one-clk pulse coincident with p_tick when hcount=0 and vcount=0
- hsync  out  1  horizontal sync, active low, registered
- vsync  out  1  vertical sync, active low, registered
- video_on  out  1  registered visible-area flag, aligned with rgb_out
- rgb_out  out  3  registered, blanked colour to the DAC pins

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n; every register clears immediately when rst_n falls.
- Reset values:
  - div_cnt=0, hcount=0, vcount=0, p_tick=0, frame_start=0
  - hsync=1, vsync=1, video_on=0, rgb_out=000
- Derived widths: H_TOTAL = 800, V_TOTAL = 525. Both fit in 10 bits; no overflow handling is needed.
- Pixel tick:
  - div_cnt counts 0..CLK_DIV-1 on every clk and wraps.
  - p_tick = (div_cnt == CLK_DIV-1), so it is high for one clk every CLK_DIV clks.
  - First p_tick is at clk cycle CLK_DIV after reset deassertion.
  - With CLK_DIV=1, p_tick is held at 1 out of reset.
- Counters (advance only on clk edges where p_tick=1):
  - hcount == H_TOTAL-1: hcount wraps to 0 and vcount increments.
  - vcount == V_TOTAL-1 at the same time: vcount wraps to 0.
  - Simultaneous H and V wrap happens on the same edge; this is the end of frame.
- Sync and blanking, stage 0 (combinational from the current counters):
  - h_active = hcount < H_DISPLAY; v_active = vcount < V_DISPLAY
  - hs0 = low for hcount in [656, 751], i.e. [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]
  - vs0 = low for vcount in [490, 491]
- Output stage, stage 1 (registered on p_tick edges):
  - hsync <= hs0; vsync <= vs0; video_on <= h_active & v_active
  - rgb_out <= (h_active & v_active) ? rgb_in : 000
  - Latency: all four outputs lag the counters by exactly one pixel period, so colour and syncs stay mutually aligned. rgb_in is therefore sampled for the pixel addressed by the current hcount/vcount.
- frame_start: combinational, equal to p_tick & (hcount==0) & (vcount==0).
- Between p_ticks, all registered outputs hold their values.
- Reset mid-frame: outputs return to their reset values asynchronously. After release, scanning restarts at (0,0) with no partial-line recovery.
- hcount and vcount are driven straight from the counter registers with no combinational logic in between, so the pixel block sees glitch-free inputs.

Decomposition:
- Shared package vga_pkg holds the eight timing constants, the derived H_TOTAL/V_TOTAL, and the RGB bit-position constants (BLUE=2, GREEN=1, RED=0). The pixel-colour block also uses these.
- One natural sub-module, vga_pix_tick: the CLK_DIV divider producing p_tick.
- Counters, sync decode and the output stage stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 5 clks with rgb_in=111 -> hcount=0, vcount=0, hsync=1, vsync=1, video_on=0, rgb_out=000. Release -> first p_tick at clk 2 and hcount reads 1 after it.
- Line wrap: run to hcount=799, vcount=10 -> on the next p_tick, hcount=0 and vcount=11. At vcount=524, hcount=799 -> next p_tick gives (0,0), with frame_start high for that one clk.
- Hsync: on vcount=100, count hsync=0 pixel periods -> exactly 96. First low pixel period follows the tick where hcount=656; hsync returns to 1 after the tick at hcount=752.
- Vsync: over one frame -> vsync low for exactly 2*800 pixel periods, starting one pixel after (hcount=0, vcount=490). Frame period is 800*525*2 = 840000 clks.
- Blanking and alignment: rgb_in=hcount[2:0] -> rgb_out equals the previous pixel's hcount[2:0] while video_on=1. rgb_out=000 whenever video_on=0, including at hcount 640..799 and vcount 480..524.
- Mid-frame reset: assert rst_n=0 asynchronously (between clk edges) at hcount=400, vcount=300 -> outputs return to reset values before the next clk edge. After release, the counters restart at 0 and the full frame timing of the Vsync scenario repeats.
